// File: rtl/dimmer_pkg.sv
// Shared codes, button indices and channel state type for the dimmer key scheduler.
package dimmer_pkg;

    localparam logic [1:0] CODE_IDLE  = 2'b00;
    localparam logic [1:0] CODE_PRESS = 2'b01;
    localparam logic [1:0] CODE_HOLD  = 2'b11;

    localparam int UP      = 0;
    localparam int DOWN    = 1;
    localparam int TOGGLE  = 2;
    localparam int NUM_BTN = 3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HOLD_WAIT = 2'd1,
        ST_REPEAT    = 2'd2
    } key_state_t;

endpackage

// File: rtl/key_channel.sv
// One button: 2-flop synchronizer, saturating debounce and press/hold/repeat FSM.
module key_channel
    import dimmer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 16,
    parameter int REPEAT_CYCLES   = 8,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn,
    output logic       level,
    output logic       req,
    output logic [1:0] req_code,
    output logic       cancel
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES) + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);
    localparam logic [TW-1:0] TMAX      = '1;

    logic          sync_p0, sync_p1;
    logic [DW-1:0] db_cnt;
    logic [TW-1:0] timer;
    logic          tmr_clr, hold_due;
    key_state_t    state, state_nxt;

    // Stage p0/p1: metastability synchronizer
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
        end
    end

    // Level is accepted on the edge the count of differing samples reaches DEBOUNCE_CYCLES
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            db_cnt <= '0;
            level  <= 1'b0;
        end else if (sync_p1 == level) begin
            db_cnt <= '0;
        end else if (db_cnt >= DEB_LAST) begin
            level  <= sync_p1;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + DW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            timer <= '0;
        end else begin
            state <= state_nxt;
            if (tmr_clr)
                timer <= '0;
            else if (timer != TMAX)
                timer <= timer + TW'(1);
        end
    end

    assign hold_due = level && (((state == ST_HOLD_WAIT) && REPEAT_EN && (timer >= HOLD_LAST)) ||
                                ((state == ST_REPEAT) && (timer >= REP_LAST)));

    always_comb begin
        state_nxt = state;
        tmr_clr   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (level) begin
                    state_nxt = ST_HOLD_WAIT;
                    tmr_clr   = 1'b1;
                end
            end
            ST_HOLD_WAIT: begin
                if (!level) begin
                    state_nxt = ST_IDLE;
                end else if (hold_due) begin
                    state_nxt = ST_REPEAT;
                    tmr_clr   = 1'b1;
                end
            end
            ST_REPEAT: begin
                if (!level)
                    state_nxt = ST_IDLE;
                else if (hold_due)
                    tmr_clr = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req      = 1'b0;
        req_code = CODE_IDLE;
        cancel   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (level) begin
                    req      = 1'b1;
                    req_code = CODE_PRESS;
                end
            end
            ST_HOLD_WAIT, ST_REPEAT: begin
                if (!level) begin
                    cancel = 1'b1;
                end else if (hold_due) begin
                    req      = 1'b1;
                    req_code = CODE_HOLD;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dimmer_key_sched.sv
// Three key channels feeding a fixed-priority (up > down > toggle) single-grant event scheduler.
module dimmer_key_sched
    import dimmer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 16,
    parameter int REPEAT_CYCLES   = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_toggle,
    output logic [1:0] up,
    output logic [1:0] down,
    output logic [1:0] toggle,
    output logic [2:0] pressed,
    output logic       event_drop
);

    logic [NUM_BTN-1:0]      btn_raw, level, req, cancel;
    logic [NUM_BTN-1:0][1:0] req_code, pend_code, cand_code;
    logic [NUM_BTN-1:0]      pend, pend_live, cand, gnt;

    assign btn_raw = {btn_toggle, btn_down, btn_up};
    assign pressed = level;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        key_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .REPEAT_EN       (i != TOGGLE)
        ) u_ch (
            .clock    (clock),
            .reset    (reset),
            .btn      (btn_raw[i]),
            .level    (level[i]),
            .req      (req[i]),
            .req_code (req_code[i]),
            .cancel   (cancel[i])
        );
    end

    // A pending hold dies when its button is released; a pending press survives
    always_comb begin
        pend_live = '0;
        cand      = '0;
        cand_code = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            pend_live[i] = pend[i] & ~(cancel[i] & (pend_code[i] == CODE_HOLD));
            cand[i]      = req[i] | pend_live[i];
            cand_code[i] = req[i] ? req_code[i] : pend_code[i];
        end
    end

    assign gnt[UP]     = cand[UP];
    assign gnt[DOWN]   = cand[DOWN] & ~cand[UP];
    assign gnt[TOGGLE] = cand[TOGGLE] & ~cand[UP] & ~cand[DOWN];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend       <= '0;
            pend_code  <= '0;
            up         <= CODE_IDLE;
            down       <= CODE_IDLE;
            toggle     <= CODE_IDLE;
            event_drop <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (gnt[i]) begin
                    pend[i] <= 1'b0;
                end else if (req[i]) begin
                    pend[i]      <= 1'b1;
                    pend_code[i] <= req_code[i];
                end else if (!pend_live[i]) begin
                    pend[i] <= 1'b0;
                end
            end
            up         <= gnt[UP]     ? cand_code[UP]     : CODE_IDLE;
            down       <= gnt[DOWN]   ? cand_code[DOWN]   : CODE_IDLE;
            toggle     <= gnt[TOGGLE] ? cand_code[TOGGLE] : CODE_IDLE;
            event_drop <= |(req & pend_live);
        end
    end

endmodule

// File: tb/tb_dimmer_key_sched.sv
// Directed bench for dimmer_key_sched: default instance plus a fast-timing instance for overwrite cases.
module tb_dimmer_key_sched;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic btn_up = 1'b0, btn_down = 1'b0, btn_toggle = 1'b0;
    logic [1:0] up, down, toggle;
    logic [2:0] pressed;
    logic event_drop;

    logic b2_up = 1'b0, b2_down = 1'b0, b2_toggle = 1'b0;
    logic [1:0] up2, down2, toggle2;
    logic [2:0] pressed2;
    logic event_drop2;

    int n_assert = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    dimmer_key_sched dut (
        .clock(clock), .reset(reset),
        .btn_up(btn_up), .btn_down(btn_down), .btn_toggle(btn_toggle),
        .up(up), .down(down), .toggle(toggle),
        .pressed(pressed), .event_drop(event_drop)
    );

    dimmer_key_sched #(.DEBOUNCE_CYCLES(1), .HOLD_CYCLES(2), .REPEAT_CYCLES(1)) dut2 (
        .clock(clock), .reset(reset),
        .btn_up(b2_up), .btn_down(b2_down), .btn_toggle(b2_toggle),
        .up(up2), .down(down2), .toggle(toggle2),
        .pressed(pressed2), .event_drop(event_drop2)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [1:0] exp_up;
        reset = 1'b0;
        btn_up = 1'b1;
        repeat (3) step();
        n_assert++;
        if ({up, down, toggle, pressed, event_drop} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b exp=0", {up, down, toggle, pressed, event_drop});
        end
        reset = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            exp_up = (k == 7) ? 2'b01 : 2'b00;
            n_assert++;
            if (up !== exp_up || down !== 2'b00 || toggle !== 2'b00) begin
                n_fail++;
                $display("FAIL first_press k=%0d got up=%b down=%b toggle=%b exp up=%b", k, up, down, toggle, exp_up);
            end
            if (k == 5 || k == 6) begin
                n_assert++;
                if (pressed[0] !== (k == 6)) begin
                    n_fail++;
                    $display("FAIL debounce_level k=%0d got=%b exp=%b", k, pressed[0], (k == 6));
                end
            end
        end
        btn_up = 1'b0;
        for (int k = 11; k <= 30; k++) begin
            step();
            n_assert++;
            if (up !== 2'b00) begin
                n_fail++;
                $display("FAIL release_in_hold_wait k=%0d got=%b exp=00", k, up);
            end
        end
    endtask

    task automatic test_bounce();
        for (int k = 0; k < 20; k++) begin
            if (k % 2 == 0) btn_up = ~btn_up;
            step();
            n_assert++;
            if (up !== 2'b00 || pressed[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL bounce k=%0d got up=%b pressed0=%b exp 00/0", k, up, pressed[0]);
            end
        end
        btn_up = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            n_assert++;
            if (up !== 2'b00 || pressed[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL bounce_tail k=%0d got up=%b pressed0=%b exp 00/0", k, up, pressed[0]);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [1:0] eu, ed;
        btn_up = 1'b1;
        btn_down = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            eu = (k == 7) ? 2'b01 : 2'b00;
            ed = (k == 8) ? 2'b01 : 2'b00;
            n_assert++;
            if (up !== eu || down !== ed || toggle !== 2'b00) begin
                n_fail++;
                $display("FAIL simultaneous k=%0d got up=%b down=%b exp up=%b down=%b", k, up, down, eu, ed);
            end
        end
        btn_up = 1'b0;
        btn_down = 1'b0;
        for (int k = 11; k <= 30; k++) begin
            step();
            n_assert++;
            if (up !== 2'b00 || down !== 2'b00) begin
                n_fail++;
                $display("FAIL simultaneous_tail k=%0d got up=%b down=%b exp 00", k, up, down);
            end
        end
    endtask

    task automatic test_hold_repeat();
        logic [1:0] ed;
        btn_down = 1'b1;
        for (int k = 1; k <= 75; k++) begin
            step();
            if (k == 7) ed = 2'b01;
            else if (k == 23 || k == 31 || k == 39 || k == 47) ed = 2'b11;
            else ed = 2'b00;
            n_assert++;
            if (down !== ed || up !== 2'b00 || event_drop !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_repeat k=%0d got down=%b up=%b drop=%b exp down=%b", k, down, up, event_drop, ed);
            end
            if (k == 52 || k == 53) begin
                n_assert++;
                if (pressed[1] !== (k == 52)) begin
                    n_fail++;
                    $display("FAIL down_release_level k=%0d got=%b exp=%b", k, pressed[1], (k == 52));
                end
            end
            if (k == 47) btn_down = 1'b0;
        end
    endtask

    task automatic test_toggle();
        logic [1:0] et;
        btn_toggle = 1'b1;
        for (int k = 1; k <= 75; k++) begin
            step();
            et = (k == 7) ? 2'b01 : 2'b00;
            n_assert++;
            if (toggle !== et) begin
                n_fail++;
                $display("FAIL toggle_hold k=%0d got=%b exp=%b", k, toggle, et);
            end
            if (k == 60) begin
                n_assert++;
                if (pressed !== 3'b100) begin
                    n_fail++;
                    $display("FAIL toggle_level got=%b exp=100", pressed);
                end
                btn_toggle = 1'b0;
            end
        end
        n_assert++;
        if (pressed !== 3'b000) begin
            n_fail++;
            $display("FAIL toggle_release got=%b exp=000", pressed);
        end
    endtask

    task automatic test_drop();
        logic [1:0] eu, ed;
        logic edr;
        b2_up = 1'b1;
        b2_down = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            eu  = (k == 4) ? 2'b01 : ((k >= 6 && k <= 15) ? 2'b11 : 2'b00);
            ed  = (k == 5) ? 2'b01 : 2'b00;
            edr = (k >= 7 && k <= 15);
            n_assert++;
            if (up2 !== eu || down2 !== ed || event_drop2 !== edr || toggle2 !== 2'b00) begin
                n_fail++;
                $display("FAIL overwrite k=%0d got up=%b down=%b drop=%b exp up=%b down=%b drop=%b",
                         k, up2, down2, event_drop2, eu, ed, edr);
            end
            if (k == 12) begin
                b2_up = 1'b0;
                b2_down = 1'b0;
            end
        end
    endtask

    task automatic test_reset_repeat();
        logic [1:0] exp_up;
        btn_up = 1'b1;
        for (int k = 1; k <= 31; k++) step();
        n_assert++;
        if (up !== 2'b11) begin
            n_fail++;
            $display("FAIL pre_reset_repeat got=%b exp=11", up);
        end
        #2 reset = 1'b0;
        #1;
        n_assert++;
        if ({up, down, toggle, pressed, event_drop} !== 10'b0) begin
            n_fail++;
            $display("FAIL async_reset got=%b exp=0", {up, down, toggle, pressed, event_drop});
        end
        step();
        step();
        reset = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            exp_up = (k == 7) ? 2'b01 : 2'b00;
            n_assert++;
            if (up !== exp_up) begin
                n_fail++;
                $display("FAIL press_after_reset k=%0d got=%b exp=%b", k, up, exp_up);
            end
        end
        btn_up = 1'b0;
        repeat (20) step();
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_simultaneous();
        test_hold_repeat();
        test_toggle();
        test_drop();
        test_reset_repeat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
